// File: rtl/trans_pkg.sv
// rtl/trans_pkg.sv - shared types and constants for the transaction issue path
package trans_pkg;

    localparam int TXN_W           = 128;
    localparam int BIT_BLOCK_START = 9;

    // Transaction field slices
    localparam int SENDER_MSB   = 127;
    localparam int SENDER_LSB   = 80;
    localparam int RECEIVER_MSB = 79;
    localparam int RECEIVER_LSB = 32;
    localparam int AMOUNT_MSB   = 31;
    localparam int AMOUNT_LSB   = 10;

    typedef logic [TXN_W-1:0] txn_t;

    typedef enum logic {
        IDLE  = 1'b0,
        ISSUE = 1'b1
    } sched_state_e;

    // Overwrite the block-start marker of a transaction
    function automatic txn_t stamp_block_start(input txn_t txn, input logic block_start);
        txn_t r;
        r = txn;
        r[BIT_BLOCK_START] = block_start;
        return r;
    endfunction

endpackage

// File: rtl/trans_issue_scheduler_rr_arbiter.sv
// rtl/trans_issue_scheduler_rr_arbiter.sv - combinational round-robin priority rotate
module rr_arbiter #(
    parameter int N = 4
) (
    input  logic [N-1:0]         req_i,
    input  logic [$clog2(N)-1:0] last_i,
    input  logic                 en_i,
    output logic [N-1:0]         grant_o,
    output logic [$clog2(N)-1:0] idx_o,
    output logic                 any_o
);

    localparam int IW = $clog2(N);

    int          k;
    logic [IW-1:0] kk;
    logic        found;

    // Search from the slot after the last winner, wrapping, and take the first pending one
    always_comb begin
        grant_o = '0;
        idx_o   = '0;
        found   = 1'b0;
        k       = 0;
        kk      = '0;
        if (en_i) begin
            for (int i = 1; i <= N; i++) begin
                k = int'(last_i) + i;
                if (k >= N) begin
                    k = k - N;
                end
                kk = k[IW-1:0];
                if (!found && req_i[kk]) begin
                    found       = 1'b1;
                    grant_o[kk] = 1'b1;
                    idx_o       = kk;
                end
            end
        end
    end

    assign any_o = en_i & (|req_i);

endmodule

// File: rtl/trans_issue_scheduler.sv
// rtl/trans_issue_scheduler.sv - round-robin issue of requester transactions to the shared validator
module trans_issue_scheduler
    import trans_pkg::*;
#(
    parameter int N_REQ          = 4,
    parameter int TIMEOUT_CYCLES = 20000,
    parameter int CNT_W          = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [N_REQ-1:0]         req_vld_i,
    input  logic [N_REQ*TXN_W-1:0]   req_data_i,
    output logic [N_REQ-1:0]         req_rdy_o,
    output logic [TXN_W-1:0]         val_data_o,
    output logic                     val_vld_o,
    input  logic                     val_ack_i,
    input  logic                     val_ok_i,
    input  logic                     ledger_clr_i,
    output logic [$clog2(N_REQ)-1:0] grant_id_o,
    output logic                     busy_o,
    output logic                     timeout_o,
    output logic [CNT_W-1:0]         issued_cnt_o,
    output logic [CNT_W-1:0]         commit_cnt_o
);

    localparam int IDX_W  = $clog2(N_REQ);
    localparam int WDOG_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [WDOG_W-1:0] WDOG_MAX = WDOG_W'(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0]  CNT_MAX  = '1;
    localparam logic [IDX_W-1:0]  RR_INIT  = IDX_W'(N_REQ - 1);

    sched_state_e      state_q, state_d;
    txn_t              txn_q, txn_d;
    logic [IDX_W-1:0]  rr_last_q, rr_last_d;
    logic [IDX_W-1:0]  grant_id_q, grant_id_d;
    logic [WDOG_W-1:0] wdog_q, wdog_d;
    logic              clr_pending_q, clr_pending_d;
    logic              timeout_q, timeout_d;
    logic [CNT_W-1:0]  issued_q, issued_d;
    logic [CNT_W-1:0]  commit_q, commit_d;

    logic [N_REQ-1:0]  arb_grant;
    logic [IDX_W-1:0]  arb_idx;
    logic              arb_any;

    rr_arbiter #(
        .N(N_REQ)
    ) u_arb (
        .req_i   (req_vld_i),
        .last_i  (rr_last_q),
        .en_i    (state_q == IDLE),
        .grant_o (arb_grant),
        .idx_o   (arb_idx),
        .any_o   (arb_any)
    );

    // Next-state: capture on grant, hold until ack, watchdog, counters and ledger clear
    always_comb begin
        state_d       = state_q;
        txn_d         = txn_q;
        rr_last_d     = rr_last_q;
        grant_id_d    = grant_id_q;
        wdog_d        = wdog_q;
        clr_pending_d = clr_pending_q;
        timeout_d     = timeout_q;
        issued_d      = issued_q;
        commit_d      = commit_q;

        case (state_q)
            IDLE: begin
                if (arb_any) begin
                    txn_d      = stamp_block_start(req_data_i[arb_idx*TXN_W +: TXN_W], clr_pending_q);
                    rr_last_d  = arb_idx;
                    grant_id_d = arb_idx;
                    wdog_d     = '0;
                    state_d    = ISSUE;
                end
            end
            ISSUE: begin
                if (wdog_q != WDOG_MAX) begin
                    wdog_d = wdog_q + 1'b1;
                end
                if (val_ack_i) begin
                    state_d = IDLE;
                    if (issued_q != CNT_MAX) begin
                        issued_d = issued_q + 1'b1;
                    end
                    if (txn_q[BIT_BLOCK_START]) begin
                        clr_pending_d = 1'b0;
                    end
                end else if (wdog_d == WDOG_MAX) begin
                    timeout_d = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (val_ok_i && (commit_q != CNT_MAX)) begin
            commit_d = commit_q + 1'b1;
        end

        // A clear overrides any same-cycle increment, stamp consumption or timeout
        if (ledger_clr_i) begin
            clr_pending_d = 1'b1;
            issued_d      = '0;
            commit_d      = '0;
            timeout_d     = 1'b0;
        end
    end

    // State register with asynchronous reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            txn_q         <= '0;
            rr_last_q     <= RR_INIT;
            grant_id_q    <= '0;
            wdog_q        <= '0;
            clr_pending_q <= 1'b1;
            timeout_q     <= 1'b0;
            issued_q      <= '0;
            commit_q      <= '0;
        end else begin
            state_q       <= state_d;
            txn_q         <= txn_d;
            rr_last_q     <= rr_last_d;
            grant_id_q    <= grant_id_d;
            wdog_q        <= wdog_d;
            clr_pending_q <= clr_pending_d;
            timeout_q     <= timeout_d;
            issued_q      <= issued_d;
            commit_q      <= commit_d;
        end
    end

    assign req_rdy_o    = arb_grant;
    assign val_vld_o    = (state_q == ISSUE);
    assign busy_o       = (state_q == ISSUE);
    assign val_data_o   = txn_q;
    assign grant_id_o   = grant_id_q;
    assign timeout_o    = timeout_q;
    assign issued_cnt_o = issued_q;
    assign commit_cnt_o = commit_q;

endmodule

// File: tb/tb_trans_issue_scheduler.sv
// tb/tb_trans_issue_scheduler.sv - scoreboard bench for trans_issue_scheduler
module tb_trans_issue_scheduler;

    localparam int N       = 4;
    localparam int TMO     = 20000;
    localparam int CW      = 5;
    localparam int CNT_MAX = (1 << CW) - 1;
    localparam int IW      = $clog2(N);

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [N-1:0]     req_vld_i = '0;
    logic [N*128-1:0] req_data_i = '0;
    logic [N-1:0]     req_rdy_o;
    logic [127:0]     val_data_o;
    logic             val_vld_o;
    logic             val_ack_i = 1'b0;
    logic             val_ok_i = 1'b0;
    logic             ledger_clr_i = 1'b0;
    logic [IW-1:0]    grant_id_o;
    logic             busy_o;
    logic             timeout_o;
    logic [CW-1:0]    issued_cnt_o;
    logic [CW-1:0]    commit_cnt_o;

    trans_issue_scheduler #(
        .N_REQ(N), .TIMEOUT_CYCLES(TMO), .CNT_W(CW)
    ) dut (
        .clk(clk), .rst(rst),
        .req_vld_i(req_vld_i), .req_data_i(req_data_i), .req_rdy_o(req_rdy_o),
        .val_data_o(val_data_o), .val_vld_o(val_vld_o),
        .val_ack_i(val_ack_i), .val_ok_i(val_ok_i), .ledger_clr_i(ledger_clr_i),
        .grant_id_o(grant_id_o), .busy_o(busy_o), .timeout_o(timeout_o),
        .issued_cnt_o(issued_cnt_o), .commit_cnt_o(commit_cnt_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [127:0] data;
        int           gid;
    } txn_s;

    typedef struct {
        logic busy;
        logic tmo;
        int   iss;
        int   com;
    } st_s;

    txn_s exp_txn_q[$];
    st_s  exp_st_q[$];
    int   gid_log[$];
    int   b9_log[$];

    int checks = 0;
    int errors = 0;

    // Reference model: what the scheduler should be holding/counting
    logic m_hold;
    int   m_last;
    logic m_clr;
    logic m_b9;
    int   m_wait;
    logic m_tmo;
    int   m_iss;
    int   m_com;

    logic         cur_valid;
    logic [127:0] cur_data;
    int           cur_gid;
    logic         prev_vld;

    task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_hold = 1'b0;
        m_last = N - 1;
        m_clr  = 1'b1;
        m_b9   = 1'b0;
        m_wait = 0;
        m_tmo  = 1'b0;
        m_iss  = 0;
        m_com  = 0;
    endtask

    // One clock of stimulus: drive, check the combinational accept strobe, advance the model
    task automatic cycle(input logic [N-1:0] mask, input logic ack, input logic ok, input logic clr);
        logic [127:0] slot [N];
        logic [127:0] d;
        logic [N-1:0] exp_rdy;
        int           g;
        st_s          st;
        txn_s         t;
        @(negedge clk);
        for (int s = 0; s < N; s++) begin
            slot[s] = {$urandom, $urandom, $urandom, $urandom};
            req_data_i[s*128 +: 128] = slot[s];
        end
        req_vld_i    = mask;
        val_ack_i    = ack;
        val_ok_i     = ok;
        ledger_clr_i = clr;
        g = -1;
        if (!m_hold) begin
            for (int i = 1; i <= N; i++) begin
                if (g < 0 && mask[(m_last + i) % N]) g = (m_last + i) % N;
            end
        end
        exp_rdy = '0;
        if (g >= 0) exp_rdy[g] = 1'b1;
        #1;
        chk("req_rdy", 128'(req_rdy_o), 128'(exp_rdy));
        if (g >= 0) begin
            d = slot[g];
            d[9] = m_clr;
            t.data = d;
            t.gid  = g;
            exp_txn_q.push_back(t);
            m_hold = 1'b1;
            m_last = g;
            m_b9   = m_clr;
            m_wait = 0;
        end else if (m_hold) begin
            m_wait++;
            if (ack) begin
                m_hold = 1'b0;
                if (m_iss < CNT_MAX) m_iss++;
                if (m_b9) m_clr = 1'b0;
            end else if (m_wait >= TMO) begin
                m_tmo = 1'b1;
            end
        end
        if (ok && m_com < CNT_MAX) m_com++;
        if (clr) begin
            m_clr = 1'b1;
            m_iss = 0;
            m_com = 0;
            m_tmo = 1'b0;
        end
        st.busy = m_hold;
        st.tmo  = m_tmo;
        st.iss  = m_iss;
        st.com  = m_com;
        exp_st_q.push_back(st);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle('0, 1'b0, 1'b0, 1'b0);
    endtask

    // Assert reset in the middle of a clock period, away from the monitor sample point
    task automatic do_reset();
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("rst_val_vld", 128'(val_vld_o), 128'(0));
        chk("rst_busy", 128'(busy_o), 128'(0));
        model_reset();
        cur_valid = 1'b0;
        req_vld_i = '0;
        val_ack_i = 1'b0;
        val_ok_i = 1'b0;
        ledger_clr_i = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    // Monitor: compare registered outputs against the scoreboard just after each edge
    initial begin
        st_s  st;
        txn_s t;
        prev_vld  = 1'b0;
        cur_valid = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (rst) begin
                prev_vld = 1'b0;
            end else begin
                if (exp_st_q.size() > 0) begin
                    st = exp_st_q.pop_front();
                    chk("busy", 128'(busy_o), 128'(st.busy));
                    chk("val_vld", 128'(val_vld_o), 128'(st.busy));
                    chk("timeout", 128'(timeout_o), 128'(st.tmo));
                    chk("issued_cnt", 128'(issued_cnt_o), 128'(st.iss));
                    chk("commit_cnt", 128'(commit_cnt_o), 128'(st.com));
                end
                if (val_vld_o && !prev_vld) begin
                    if (exp_txn_q.size() == 0) begin
                        chk("unexpected_txn", 128'(1), 128'(0));
                        cur_valid = 1'b0;
                    end else begin
                        t = exp_txn_q.pop_front();
                        cur_valid = 1'b1;
                        cur_data  = t.data;
                        cur_gid   = t.gid;
                        gid_log.push_back(int'(grant_id_o));
                        b9_log.push_back(int'(val_data_o[9]));
                    end
                end
                if (val_vld_o && cur_valid) begin
                    chk("val_data", val_data_o, cur_data);
                    chk("grant_id", 128'(grant_id_o), 128'(cur_gid));
                end
                prev_vld = val_vld_o;
            end
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "time limit");
    end

    initial begin
        int exp_gid [6];
        logic ack;
        exp_gid = '{0, 1, 2, 3, 0, 1};
        model_reset();

        // Reset state
        #1;
        chk("reset_val_vld", 128'(val_vld_o), 128'(0));
        chk("reset_val_data", val_data_o, 128'(0));
        chk("reset_busy", 128'(busy_o), 128'(0));
        chk("reset_timeout", 128'(timeout_o), 128'(0));
        chk("reset_issued", 128'(issued_cnt_o), 128'(0));
        chk("reset_commit", 128'(commit_cnt_o), 128'(0));
        chk("reset_grant_id", 128'(grant_id_o), 128'(0));
        chk("reset_req_rdy", 128'(req_rdy_o), 128'(0));
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // Single requester, ack on the second valid cycle
        cycle(4'b0001, 1'b0, 1'b0, 1'b0);
        cycle(4'b0000, 1'b0, 1'b0, 1'b0);
        cycle(4'b0000, 1'b1, 1'b0, 1'b0);
        idle(2);
        chk("t1_b9", 128'(b9_log[0]), 128'(1));

        // All requesters held: strict rotation from requester 0
        do_reset();
        gid_log.delete();
        b9_log.delete();
        for (int r = 0; r < 6; r++) begin
            cycle(4'b1111, 1'b0, 1'b0, 1'b0);
            cycle(4'b1111, 1'b0, 1'b0, 1'b0);
            cycle(4'b1111, 1'b1, 1'b0, 1'b0);
        end
        idle(2);
        chk("t2_count", 128'(gid_log.size()), 128'(6));
        for (int r = 0; r < 6 && r < gid_log.size(); r++) begin
            chk("t2_gid_order", 128'(gid_log[r]), 128'(exp_gid[r]));
            chk("t2_b9", 128'(b9_log[r]), 128'(r == 0 ? 1 : 0));
        end

        // Stuck validator: watchdog fires while the transaction stays held
        cycle(4'b0010, 1'b0, 1'b0, 1'b0);
        idle(TMO + 3);
        chk("t3_vld_held", 128'(val_vld_o), 128'(1));
        cycle(4'b0000, 1'b1, 1'b0, 1'b0);
        idle(2);
        chk("t3_timeout_sticky", 128'(timeout_o), 128'(1));

        // Ledger clear while a transaction is held applies to the next capture
        cycle(4'b0100, 1'b0, 1'b0, 1'b0);
        cycle(4'b0000, 1'b0, 1'b0, 1'b1);
        cycle(4'b0000, 1'b1, 1'b0, 1'b0);
        cycle(4'b1000, 1'b0, 1'b0, 1'b0);
        cycle(4'b0000, 1'b0, 1'b0, 1'b0);
        cycle(4'b0000, 1'b1, 1'b0, 1'b0);
        idle(2);

        // Commit count: clear beats a same-cycle pulse, then saturation
        cycle(4'b0000, 1'b0, 1'b1, 1'b0);
        cycle(4'b0000, 1'b0, 1'b1, 1'b1);
        for (int i = 0; i < CNT_MAX + 6; i++) cycle(4'b0000, 1'b0, 1'b1, 1'b0);
        idle(2);
        chk("t5_commit_sat", 128'(commit_cnt_o), 128'(CNT_MAX));

        // Ack while idle must be ignored
        cycle(4'b0000, 1'b1, 1'b0, 1'b0);
        idle(1);

        // Reset in the middle of ISSUE
        cycle(4'b0100, 1'b0, 1'b0, 1'b0);
        cycle(4'b0000, 1'b0, 1'b0, 1'b0);
        do_reset();
        gid_log.delete();
        b9_log.delete();
        cycle(4'b1111, 1'b0, 1'b0, 1'b0);
        cycle(4'b0000, 1'b1, 1'b0, 1'b0);
        idle(2);
        chk("t6_first_gid", 128'(gid_log.size() > 0 ? gid_log[0] : -1), 128'(0));
        chk("t6_first_b9", 128'(b9_log.size() > 0 ? b9_log[0] : -1), 128'(1));

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            if (m_hold) ack = ($urandom_range(0, 2) == 0);
            else        ack = ($urandom_range(0, 4) == 0);
            cycle(N'($urandom_range(0, 15)), ack, ($urandom_range(0, 3) == 0),
                  ($urandom_range(0, 39) == 0));
        end
        for (int i = 0; i < 10; i++) cycle('0, m_hold, 1'b0, 1'b0);
        @(posedge clk);
        #3;
        chk("txn_queue_drained", 128'(exp_txn_q.size()), 128'(0));
        chk("state_queue_drained", 128'(exp_st_q.size()), 128'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
